// File: rtl/rv_multicycle_ctrl.sv
// Multicycle control FSM for the 64-bit RISC-V datapath (FETCH/DECODE/EXEC/MEM/WB/HALT).
// Latency: FETCH to retire is BR 3, R/I/LUI/SD/JAL 4, LD 5 cycles.
// Backpressure: stall freezes state/class and zeroes all enables and retired in that cycle.
//
// Ports:
//   clk, rst        - clock (rising edge), synchronous active-high reset
//   stall           - freeze request from the datapath/memories
//   opcode, func3   - IR[6:0] and IR[14:12] from the datapath
//   alu_flags       - bit0 zero, bit1 MSB, bit2 overflow, bit3 unused
//   ir_we, pc_we    - IR / PC load enables
//   pc_src          - 0 = PC+4, 1 = PC+imm
//   alu_cmd         - ALU format select (R, I, S, SB, U, UJ)
//   alu_src, rf_src - ALU operand B select, register file write-data select
//   rf_we, d_mem_we - register file / data memory write enables
//   retired         - one-cycle pulse in the last cycle of each instruction
//   halted          - sticky illegal-instruction indicator (cleared by rst)
//   state           - current FSM state for debug
module rv_multicycle_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       stall,
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic [3:0] alu_flags,
  output logic       ir_we,
  output logic       pc_we,
  output logic       pc_src,
  output logic [3:0] alu_cmd,
  output logic       alu_src,
  output logic       rf_src,
  output logic       rf_we,
  output logic       d_mem_we,
  output logic       retired,
  output logic       halted,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    C_R   = 3'd0,
    C_I   = 3'd1,
    C_LD  = 3'd2,
    C_SD  = 3'd3,
    C_BR  = 3'd4,
    C_LUI = 3'd5,
    C_JAL = 3'd6
  } cls_e;

  state_e     state_q, state_d;
  cls_e       cls_q, cls_d;
  logic [2:0] f3_q, f3_d;

  cls_e       dec_cls;
  logic       dec_legal;
  logic       lt;
  logic       taken;

  // Bit 3 of the flags carries no meaning for branch evaluation.
  logic       unused_flag;
  assign unused_flag = alu_flags[3];

  function automatic logic [3:0] cmd_of(input cls_e c);
    case (c)
      C_R:          cmd_of = 4'b0000;
      C_I, C_LD:    cmd_of = 4'b0001;
      C_SD:         cmd_of = 4'b0010;
      C_BR:         cmd_of = 4'b0011;
      C_LUI:        cmd_of = 4'b0100;
      C_JAL:        cmd_of = 4'b0101;
      default:      cmd_of = 4'b0000;
    endcase
  endfunction

  // Opcode decode; branches with an unsupported condition are illegal too.
  always_comb begin
    dec_cls   = C_R;
    dec_legal = 1'b1;
    case (opcode)
      7'b0110011: dec_cls = C_R;
      7'b0010011: dec_cls = C_I;
      7'b0000011: dec_cls = C_LD;
      7'b0100011: dec_cls = C_SD;
      7'b1100011: begin
        dec_cls   = C_BR;
        dec_legal = (func3 == 3'b000) || (func3 == 3'b001) ||
                    (func3 == 3'b100) || (func3 == 3'b101);
      end
      7'b0110111: dec_cls = C_LUI;
      7'b1101111: dec_cls = C_JAL;
      default:    dec_legal = 1'b0;
    endcase
  end

  // Signed less-than from the subtraction flags: MSB xor overflow.
  assign lt = alu_flags[1] ^ alu_flags[2];

  always_comb begin
    case (f3_q)
      3'b000:  taken = alu_flags[0];
      3'b001:  taken = ~alu_flags[0];
      3'b100:  taken = lt;
      default: taken = ~lt;
    endcase
  end

  // Next state; stall holds everything, including HALT entry from DECODE.
  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    f3_d    = f3_q;
    if (!stall) begin
      case (state_q)
        S_FETCH:  state_d = S_DECODE;
        S_DECODE: begin
          if (dec_legal) begin
            cls_d   = dec_cls;
            f3_d    = func3;
            state_d = S_EXEC;
          end else begin
            state_d = S_HALT;
          end
        end
        S_EXEC: begin
          case (cls_q)
            C_LD, C_SD: state_d = S_MEM;
            C_BR:       state_d = S_FETCH;
            default:    state_d = S_WB;
          endcase
        end
        S_MEM:    state_d = (cls_q == C_SD) ? S_FETCH : S_WB;
        S_WB:     state_d = S_FETCH;
        S_HALT:   state_d = S_HALT;
        default:  state_d = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      cls_q   <= C_R;
      f3_q    <= 3'b000;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      f3_q    <= f3_d;
    end
  end

  // Output decode from registered state/class. pc_src in branch EXEC is the
  // only flag-dependent output. stall and rst gate in the same cycle, so
  // these cannot be registered.
  always_comb begin
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    pc_src   = 1'b0;
    alu_cmd  = 4'b0000;
    alu_src  = 1'b0;
    rf_src   = 1'b0;
    rf_we    = 1'b0;
    d_mem_we = 1'b0;
    retired  = 1'b0;
    halted   = 1'b0;
    case (state_q)
      S_FETCH: ir_we = 1'b1;
      S_EXEC: begin
        alu_cmd = cmd_of(cls_q);
        alu_src = (cls_q != C_R) && (cls_q != C_BR);
        if (cls_q == C_BR) begin
          pc_we   = 1'b1;
          pc_src  = taken;
          retired = 1'b1;
        end else if (cls_q == C_JAL) begin
          pc_we  = 1'b1;
          pc_src = 1'b1;
        end
      end
      S_MEM: begin
        alu_cmd = cmd_of(cls_q);
        if (cls_q == C_SD) begin
          d_mem_we = 1'b1;
          pc_we    = 1'b1;
          retired  = 1'b1;
        end
      end
      S_WB: begin
        alu_cmd = cmd_of(cls_q);
        rf_we   = 1'b1;
        rf_src  = (cls_q == C_LD);
        retired = 1'b1;
        // JAL already loaded the PC in EXEC.
        pc_we   = (cls_q != C_JAL);
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase

    if (stall) begin
      ir_we    = 1'b0;
      pc_we    = 1'b0;
      rf_we    = 1'b0;
      d_mem_we = 1'b0;
      retired  = 1'b0;
    end

    // The reset cycle discards the partial instruction: nothing is driven.
    if (rst) begin
      ir_we    = 1'b0;
      pc_we    = 1'b0;
      pc_src   = 1'b0;
      alu_cmd  = 4'b0000;
      alu_src  = 1'b0;
      rf_src   = 1'b0;
      rf_we    = 1'b0;
      d_mem_we = 1'b0;
      retired  = 1'b0;
      halted   = 1'b0;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
module tb_rv_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       stall;
  logic [6:0] opcode;
  logic [2:0] func3;
  logic [3:0] alu_flags;
  logic       ir_we, pc_we, pc_src, alu_src, rf_src, rf_we, d_mem_we, retired, halted;
  logic [3:0] alu_cmd;
  logic [2:0] state;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rv_multicycle_ctrl dut (
    .clk(clk), .rst(rst), .stall(stall), .opcode(opcode), .func3(func3),
    .alu_flags(alu_flags), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
    .alu_cmd(alu_cmd), .alu_src(alu_src), .rf_src(rf_src), .rf_we(rf_we),
    .d_mem_we(d_mem_we), .retired(retired), .halted(halted), .state(state)
  );

  typedef struct packed {
    logic [2:0] st;
    logic       ir_we;
    logic       pc_we;
    logic       pc_src;
    logic [3:0] cmd;
    logic       alu_src;
    logic       rf_src;
    logic       rf_we;
    logic       d_mem_we;
    logic       retired;
    logic       halted;
  } row_t;

  // Instruction classes of the reference model (-1 = illegal).
  localparam int K_R = 0, K_I = 1, K_LD = 2, K_SD = 3, K_BR = 4, K_LUI = 5, K_JAL = 6;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                         OP_SD = 7'b0100011, OP_BR = 7'b1100011, OP_LUI = 7'b0110111,
                         OP_JAL = 7'b1101111, OP_BAD = 7'b1111111;

  row_t m_full;
  row_t m_enab;

  function automatic int cls_of(input logic [6:0] opc, input logic [2:0] f3);
    case (opc)
      OP_R:   return K_R;
      OP_I:   return K_I;
      OP_LD:  return K_LD;
      OP_SD:  return K_SD;
      OP_BR:  return (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd4 || f3 == 3'd5) ? K_BR : -1;
      OP_LUI: return K_LUI;
      OP_JAL: return K_JAL;
      default: return -1;
    endcase
  endfunction

  function automatic int n_rows(input int c);
    if (c < 0) return 2;
    if (c == K_BR) return 3;
    if (c == K_LD) return 5;
    return 4;
  endfunction

  function automatic logic [3:0] cmd_of(input int c);
    case (c)
      K_R:        return 4'd0;
      K_I, K_LD:  return 4'd1;
      K_SD:       return 4'd2;
      K_BR:       return 4'd3;
      K_LUI:      return 4'd4;
      default:    return 4'd5;
    endcase
  endfunction

  function automatic logic br_taken(input logic [2:0] f3, input logic [3:0] fl);
    int zero;
    int lt;
    zero = fl[0];
    lt   = (fl[1] != fl[2]) ? 1 : 0;
    case (f3)
      3'd0:    return zero == 1;
      3'd1:    return zero == 0;
      3'd4:    return lt == 1;
      default: return lt == 0;
    endcase
  endfunction

  // Expected outputs for cycle idx of an instruction, straight from the
  // per-step rules: FETCH, DECODE, EXEC, optional MEM, optional WB.
  function automatic row_t row_at(input int c, input logic [2:0] f3, input int idx,
                                  input logic [3:0] fl);
    row_t r;
    bit   has_mem;
    r = '0;
    has_mem = (c == K_LD || c == K_SD);
    if (idx == 0) begin
      r.st = 3'd0; r.ir_we = 1'b1;
    end else if (idx == 1) begin
      r.st = 3'd1;
    end else if (idx == 2) begin
      r.st = 3'd2; r.cmd = cmd_of(c);
      r.alu_src = (c != K_R && c != K_BR);
      if (c == K_BR) begin
        r.pc_we = 1'b1; r.pc_src = br_taken(f3, fl); r.retired = 1'b1;
      end
      if (c == K_JAL) begin
        r.pc_we = 1'b1; r.pc_src = 1'b1;
      end
    end else if (idx == 3 && has_mem) begin
      r.st = 3'd3; r.cmd = cmd_of(c);
      if (c == K_SD) begin
        r.d_mem_we = 1'b1; r.pc_we = 1'b1; r.retired = 1'b1;
      end
    end else begin
      r.st = 3'd4; r.cmd = cmd_of(c); r.rf_we = 1'b1;
      r.rf_src = (c == K_LD); r.retired = 1'b1; r.pc_we = (c != K_JAL);
    end
    return r;
  endfunction

  task automatic check(input row_t e, input row_t m, input string tag);
    row_t o;
    o = '{st: state, ir_we: ir_we, pc_we: pc_we, pc_src: pc_src, cmd: alu_cmd,
          alu_src: alu_src, rf_src: rf_src, rf_we: rf_we, d_mem_we: d_mem_we,
          retired: retired, halted: halted};
    checks++;
    assert ((o & m) === (e & m))
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, o & m, e & m);
    end
  endtask

  // One instruction cycle: drive inputs, check at the falling edge, advance.
  task automatic one(input int c, input logic [2:0] f3, input int idx, input bit st,
                     input logic [3:0] fl, input string tag);
    row_t e;
    rst = 1'b0; stall = st; alu_flags = fl;
    e = row_at(c, f3, idx, fl);
    if (st) begin
      e.ir_we = 1'b0; e.pc_we = 1'b0; e.rf_we = 1'b0; e.d_mem_we = 1'b0; e.retired = 1'b0;
    end
    @(negedge clk);
    check(e, m_full, tag);
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input logic [2:0] cur_state, input bit st, input string tag);
    row_t e;
    rst = 1'b1; stall = st; alu_flags = 4'($urandom);
    e = '0; e.st = cur_state;
    @(negedge clk);
    check(e, m_enab, tag);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic halt_cycles(input int n, input int stall_pct, input string tag);
    row_t e;
    e = '0; e.st = 3'd7; e.halted = 1'b1;
    for (int k = 0; k < n; k++) begin
      rst = 1'b0; stall = ($urandom_range(99) < stall_pct); alu_flags = 4'($urandom);
      @(negedge clk);
      check(e, m_full, tag);
      @(posedge clk); #1;
    end
  endtask

  // Runs a whole instruction; an illegal one is followed by HALT and a reset.
  task automatic run_instr(input logic [6:0] opc, input logic [2:0] f3, input bit fix_fl,
                           input logic [3:0] fl_fixed, input int stall_pct, input string tag);
    int   c;
    int   idx;
    int   guard;
    bit   st;
    logic [3:0] fl;
    c = cls_of(opc, f3);
    opcode = opc; func3 = f3;
    idx = 0; guard = 0;
    while (idx < n_rows(c) && guard < 200) begin
      st = ($urandom_range(99) < stall_pct);
      fl = fix_fl ? fl_fixed : 4'($urandom);
      one(c, f3, idx, st, fl, tag);
      if (!st) idx++;
      guard++;
    end
    if (c < 0) begin
      halt_cycles(10, stall_pct, {tag, "_halt"});
      do_reset(3'd7, 1'b0, {tag, "_rst"});
    end
  endtask

  logic [6:0] opc_tab [8];

  initial begin
    m_full = '1;
    m_enab = '0;
    m_enab.st = '1; m_enab.ir_we = 1'b1; m_enab.pc_we = 1'b1; m_enab.rf_we = 1'b1;
    m_enab.d_mem_we = 1'b1; m_enab.retired = 1'b1;
    opc_tab = '{OP_R, OP_I, OP_LD, OP_SD, OP_BR, OP_LUI, OP_JAL, OP_BAD};

    rst = 1'b1; stall = 1'b0; opcode = OP_R; func3 = 3'd0; alu_flags = 4'd0;
    @(posedge clk); #1;
    begin
      row_t z;
      z = '0;
      @(negedge clk);
      check(z, m_full, "reset_state");
      @(posedge clk); #1;
    end
    rst = 1'b0;

    // Directed: one of each class, then the branch-condition corners.
    run_instr(OP_R,   3'd0, 1'b0, 4'd0, 0, "r_add");
    run_instr(OP_LD,  3'd3, 1'b0, 4'd0, 0, "ld");
    run_instr(OP_SD,  3'd3, 1'b0, 4'd0, 0, "sd");
    run_instr(OP_BR,  3'd0, 1'b1, 4'b0001, 0, "beq_z1");
    run_instr(OP_BR,  3'd1, 1'b1, 4'b0001, 0, "bne_z1");
    run_instr(OP_BR,  3'd4, 1'b1, 4'b0110, 0, "blt_m1v1");
    run_instr(OP_BR,  3'd5, 1'b1, 4'b0000, 0, "bge_m0v0");
    run_instr(OP_JAL, 3'd0, 1'b0, 4'd0, 0, "jal");
    run_instr(OP_I,   3'd0, 1'b0, 4'd0, 0, "i_addi");
    run_instr(OP_LUI, 3'd0, 1'b0, 4'd0, 0, "lui");
    run_instr(OP_BAD, 3'd0, 1'b0, 4'd0, 0, "illegal_op");
    run_instr(OP_BR,  3'd6, 1'b0, 4'd0, 0, "illegal_br");

    // SD stalled three cycles in MEM, then released.
    opcode = OP_SD; func3 = 3'd3;
    for (int i = 0; i < 3; i++) one(K_SD, 3'd3, i, 1'b0, 4'd0, "sd_stall_pre");
    for (int i = 0; i < 3; i++) one(K_SD, 3'd3, 3, 1'b1, 4'd0, "sd_stall_mem");
    one(K_SD, 3'd3, 3, 1'b0, 4'd0, "sd_stall_release");

    // SD stalled in MEM and reset while stalled.
    for (int i = 0; i < 3; i++) one(K_SD, 3'd3, i, 1'b0, 4'd0, "sd_rst_pre");
    one(K_SD, 3'd3, 3, 1'b1, 4'd0, "sd_rst_stall");
    do_reset(3'd3, 1'b1, "sd_rst_during_stall");
    run_instr(OP_R, 3'd0, 1'b0, 4'd0, 0, "after_rst");

    // Random instruction stream with random stalls and flags.
    for (int n = 0; n < 150; n++) begin
      logic [6:0] opc;
      logic [2:0] f3;
      opc = opc_tab[$urandom_range(7)];
      f3  = 3'($urandom_range(7));
      run_instr(opc, f3, 1'b0, 4'd0, 25, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rv_multicycle_ctrl.md
# rv_multicycle_ctrl

Multicycle control unit for the 64-bit RISC-V datapath. Registers the decoded instruction class, walks a FETCH/DECODE/EXEC/MEM/WB state machine and drives every datapath control input, including the IR and PC load enables. Branch decisions come from the ALU flags. Sits beside the datapath in the processor top level; instruction and data memories are single-cycle synchronous.

## Interface
- No parameters.
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous reset, active-high.
- `stall` in 1: freeze FSM; while high all write enables are 0.
- `opcode` in 7: IR[6:0] from the datapath.
- `func3` in 3: IR[14:12].
- `alu_flags` in 4: bit0 zero, bit1 MSB, bit2 overflow, bit3 unused.
- `ir_we` out 1: IR load enable.
- `pc_we` out 1: PC load enable.
- `pc_src` out 1: 0 = PC+4, 1 = PC+imm.
- `alu_cmd` out 4: 0000 R, 0001 I, 0010 S, 0011 SB, 0100 U, 0101 UJ.
- `alu_src` out 1: 0 = rf, 1 = imm.
- `rf_src` out 1: 0 = alu, 1 = d_mem.
- `rf_we` out 1: register file write enable.
- `d_mem_we` out 1: data memory write enable.
- `retired` out 1: one-cycle pulse in the last cycle of each instruction.
- `halted` out 1: sticky illegal-instruction indicator.
- `state` out 3: current state, for debug.

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7.
- Instruction classes, decoded in DECODE from opcode and registered:
  - R 0110011
  - I 0010011
  - LD 0000011
  - SD 0100011
  - BR 1100011
  - LUI 0110111
  - JAL 1101111
- Any other opcode → HALT. BR with func3 ∉ {000, 001, 100, 101} → HALT.
- All outputs default to 0 (alu_cmd 0000) unless listed below.
- FETCH: ir_we=1 → DECODE.
- DECODE: drives no outputs; latches the class → EXEC, or HALT if illegal.
- EXEC: alu_cmd from class (R 0000; I and LD 0001; SD 0010; BR 0011; LUI 0100; JAL 0101). alu_src=1 for all classes except R and BR.
  - R, I, LUI → WB.
  - LD, SD → MEM.
  - BR: pc_we=1. pc_src=taken, evaluated combinationally from alu_flags in this cycle. retired=1 → FETCH.
    - beq (000): zero.
    - bne (001): !zero.
    - blt (100): MSB^overflow.
    - bge (101): !(MSB^overflow).
  - JAL: pc_we=1, pc_src=1 → WB. rd receives the link computed by the datapath under UJ.
- MEM: alu_cmd held from EXEC.
  - SD: d_mem_we=1, pc_we=1, pc_src=0, retired=1 → FETCH.
  - LD → WB.
- WB: alu_cmd held; rf_we=1; rf_src=1 for LD, else 0. retired=1 → FETCH.
  - Non-JAL: pc_we=1, pc_src=0.
  - JAL: pc_we=0 (PC already updated).
- HALT: halted=1, all enables 0. Stays in HALT until rst.
- stall=1: state and class registers hold. ir_we, pc_we, rf_we, d_mem_we and retired are forced 0. alu_cmd, alu_src, rf_src and pc_src keep their state values.

## Timing
- Reset: state=FETCH, class=R, all outputs 0. halted=0.
- rst is sampled on the clock edge; rst asserted in any state, including HALT or mid-instruction, returns to FETCH on the next edge. The partial instruction is discarded and no enables are asserted in the reset cycle.
- Latency FETCH→retire, in cycles:
  - R, I, LUI: 4.
  - LD: 5.
  - SD: 4.
  - BR: 3.
  - JAL: 4.
- Exactly one retired pulse per legal instruction.
- Exactly one pc_we pulse per legal instruction; it coincides with retired, except JAL, where it is in EXEC.
- pc_src is Mealy in BR EXEC only. alu_flags must be valid in that cycle.
- rst has priority over stall; stall has priority over HALT entry.

## Test plan
- Reset, then R-type add (0110011): state 0,1,2,4,0.
  - ir_we only in cycle 0.
  - WB: rf_we=1, rf_src=0, alu_cmd=0000, pc_we=1, pc_src=0, retired=1.
- LD (0000011): 5 cycles; MEM has no write enables; WB has rf_src=1, rf_we=1. SD (0100011): MEM has d_mem_we=1, pc_we=1, retired=1; rf_we is never asserted.
- BR:
  - beq with zero=1: EXEC pc_src=1, pc_we=1, retired=1, back to FETCH.
  - bne with zero=1: pc_src=0.
  - blt with MSB=1, overflow=1: pc_src=0.
  - bge with MSB=0, overflow=0: pc_src=1.
- JAL: EXEC pc_we=1, pc_src=1, alu_cmd=0101. WB rf_we=1, pc_we=0, retired=1.
- Illegal opcode 1111111, and BR with func3=110: DECODE→HALT; halted=1 and all enables 0 for 10 cycles. rst=1 for one edge → FETCH, halted=0.
- stall=1 for 3 cycles during SD MEM: state stays 3 and d_mem_we=0. After release, d_mem_we pulses once. rst during stall → FETCH.
